// File: rtl/health_tracker.sv
// Hit-point bookkeeping for the player and the NPC, with post-hit invulnerability
// counted in video frames and per-pixel health-bar flags for the color mapper.
module health_tracker #(
    parameter logic [6:0] MAX_HP        = 7'd100,
    parameter logic [6:0] HIT_DAMAGE    = 7'd10,
    parameter logic [5:0] INVULN_FRAMES = 6'd30,
    parameter logic [9:0] BAR_Y_TOP     = 10'd20,
    parameter logic [9:0] BAR_HEIGHT    = 10'd10,
    parameter logic [9:0] PLAYER_BAR_X  = 10'd20,
    parameter logic [9:0] NPC_BAR_X_END = 10'd619
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       Soft_Reset,
    input  logic       game_l,
    input  logic       Player_Hit,
    input  logic       NPC_Hit,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    output logic [6:0] Player_HP,
    output logic [6:0] NPC_HP,
    output logic       Player_Dead,
    output logic       NPC_Dead,
    output logic       is_player_bar,
    output logic       is_npc_bar
);

    // VS is asynchronous to Clk: two sync flops, then a history flop for edge detect.
    logic frame_sync1_reg, frame_sync2_reg, frame_hist_reg;
    logic frame_tick;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            frame_sync1_reg <= 1'b0;
            frame_sync2_reg <= 1'b0;
            frame_hist_reg  <= 1'b0;
        end else begin
            frame_sync1_reg <= frame_clk;
            frame_sync2_reg <= frame_sync1_reg;
            frame_hist_reg  <= frame_sync2_reg;
        end
    end

    assign frame_tick = frame_sync2_reg & ~frame_hist_reg;

    // Index 0 is the player, index 1 the NPC.
    logic [1:0] hit;
    logic [6:0] hp   [2];
    logic       dead [2];

    assign hit = {NPC_Hit, Player_Hit};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fighter
            logic [6:0] hp_reg, hp_next;
            logic [5:0] invuln_reg, invuln_next;
            logic       dead_reg;
            logic       accept;

            assign accept = hit[gi] & game_l & ~dead_reg & (invuln_reg == 6'd0) & ~Soft_Reset;

            always_comb begin
                hp_next     = hp_reg;
                invuln_next = invuln_reg;
                if (Soft_Reset) begin
                    hp_next     = MAX_HP;
                    invuln_next = 6'd0;
                end else if (accept) begin
                    hp_next     = (hp_reg > HIT_DAMAGE) ? hp_reg - HIT_DAMAGE : 7'd0;
                    invuln_next = INVULN_FRAMES;
                end else if (frame_tick && invuln_reg != 6'd0) begin
                    invuln_next = invuln_reg - 6'd1;
                end
            end

            always_ff @(posedge Clk or posedge Reset) begin
                if (Reset) begin
                    hp_reg     <= MAX_HP;
                    invuln_reg <= 6'd0;
                    dead_reg   <= 1'b0;
                end else begin
                    hp_reg     <= hp_next;
                    invuln_reg <= invuln_next;
                    dead_reg   <= (hp_next == 7'd0);
                end
            end

            assign hp[gi]   = hp_reg;
            assign dead[gi] = dead_reg;
        end
    endgenerate

    assign Player_HP   = hp[0];
    assign NPC_HP      = hp[1];
    assign Player_Dead = dead[0];
    assign NPC_Dead    = dead[1];

    // Bars are 2 pixels per HP; the NPC bar is anchored on its right edge.
    logic [9:0] player_width, npc_width, npc_left;
    logic       in_rows;

    assign player_width = {2'b00, hp[0], 1'b0};
    assign npc_width    = {2'b00, hp[1], 1'b0};
    assign npc_left     = NPC_BAR_X_END + 10'd1 - npc_width;
    assign in_rows      = (DrawY >= BAR_Y_TOP) && (DrawY < BAR_Y_TOP + BAR_HEIGHT);

    assign is_player_bar = in_rows && (DrawX >= PLAYER_BAR_X) &&
                           (DrawX < PLAYER_BAR_X + player_width);
    assign is_npc_bar    = in_rows && (hp[1] != 7'd0) &&
                           (DrawX >= npc_left) && (DrawX <= NPC_BAR_X_END);

endmodule

// File: tb/tb_health_tracker.sv
// Directed bench for health_tracker: expected values are queued as stimulus is
// applied and popped against the DUT outputs once they are due.
module tb_health_tracker;

    logic       Clk, Reset, frame_clk, Soft_Reset, game_l, Player_Hit, NPC_Hit;
    logic [9:0] DrawX, DrawY;
    logic [6:0] Player_HP, NPC_HP;
    logic       Player_Dead, NPC_Dead, is_player_bar, is_npc_bar;

    health_tracker dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .Soft_Reset(Soft_Reset),
        .game_l(game_l), .Player_Hit(Player_Hit), .NPC_Hit(NPC_Hit),
        .DrawX(DrawX), .DrawY(DrawY),
        .Player_HP(Player_HP), .NPC_HP(NPC_HP),
        .Player_Dead(Player_Dead), .NPC_Dead(NPC_Dead),
        .is_player_bar(is_player_bar), .is_npc_bar(is_npc_bar)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_item_t;

    sb_item_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic push(input string tag, input logic [31:0] exp);
        sb_item_t it;
        it.tag = tag;
        it.exp = exp;
        sb.push_back(it);
    endtask

    task automatic pop_cmp(input logic [31:0] obs);
        sb_item_t it;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%0d expected=none", obs);
        end else begin
            it = sb.pop_front();
            assert (obs === it.exp) else begin
                errors++;
                $error("FAIL %s observed=%0d expected=%0d", it.tag, obs, it.exp);
            end
        end
    endtask

    task automatic push_state(input string tag, input int php, input int nhp,
                              input int pd, input int nd);
        push({tag, ".Player_HP"}, php);
        push({tag, ".NPC_HP"}, nhp);
        push({tag, ".Player_Dead"}, pd);
        push({tag, ".NPC_Dead"}, nd);
    endtask

    task automatic pop_state();
        pop_cmp({25'd0, Player_HP});
        pop_cmp({25'd0, NPC_HP});
        pop_cmp({31'd0, Player_Dead});
        pop_cmp({31'd0, NPC_Dead});
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    // One VS pulse: high long enough to cross the synchronizer, then low.
    task automatic frames(input int n);
        repeat (n) begin
            frame_clk = 1'b1;
            cycles(3);
            frame_clk = 1'b0;
            cycles(5);
        end
    endtask

    // Drive one cycle of inputs; the registered result is due after the next edge.
    task automatic step(input string tag, input bit p, input bit n, input bit sr,
                        input bit gl, input int php, input int nhp,
                        input int pd, input int nd);
        Player_Hit = p;
        NPC_Hit    = n;
        Soft_Reset = sr;
        game_l     = gl;
        push_state(tag, php, nhp, pd, nd);
        @(posedge Clk);
        #1;
        Player_Hit = 1'b0;
        NPC_Hit    = 1'b0;
        Soft_Reset = 1'b0;
        game_l     = 1'b1;
        pop_state();
    endtask

    task automatic bar(input string tag, input int x, input int y,
                       input bit ep, input bit en);
        DrawX = x[9:0];
        DrawY = y[9:0];
        push({tag, ".is_player_bar"}, ep);
        push({tag, ".is_npc_bar"}, en);
        #1;
        pop_cmp({31'd0, is_player_bar});
        pop_cmp({31'd0, is_npc_bar});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset = 1'b0; frame_clk = 1'b0; Soft_Reset = 1'b0; game_l = 1'b0;
        Player_Hit = 1'b0; NPC_Hit = 1'b0; DrawX = 10'd0; DrawY = 10'd0;

        // Reset takes effect before any clock edge.
        #1 Reset = 1'b1;
        push_state("reset", 100, 100, 0, 0);
        #1 pop_state();
        cycles(2);
        Reset  = 1'b0;
        game_l = 1'b1;
        cycles(1);

        frames(5);
        push_state("idle5", 100, 100, 0, 0);
        pop_state();

        // Player hit, invulnerability window, and the first frame it expires.
        step("p_hit1", 1, 0, 0, 1, 90, 100, 0, 0);
        frames(10);
        step("p_inv10", 1, 0, 0, 1, 90, 100, 0, 0);
        frames(19);
        step("p_inv29", 1, 0, 0, 1, 90, 100, 0, 0);
        frames(1);
        step("p_hit2", 1, 0, 0, 1, 80, 100, 0, 0);

        // Drain the NPC to zero with saturation, then one extra hit.
        for (int i = 1; i <= 10; i++) begin
            if (i > 1) frames(30);
            step($sformatf("n_hit%0d", i), 0, 1, 0, 1, 80, 100 - 10 * i, 0, (i == 10) ? 1 : 0);
        end
        frames(30);
        step("n_dead_hit", 0, 1, 0, 1, 80, 0, 0, 1);
        step("soft_reset", 0, 0, 1, 1, 100, 100, 0, 0);

        step("both_hit", 1, 1, 0, 1, 90, 90, 0, 0);
        step("hit_with_soft", 1, 1, 1, 1, 100, 100, 0, 0);
        step("hit_no_game", 1, 1, 0, 0, 100, 100, 0, 0);
        step("p_hit_game", 1, 0, 0, 1, 90, 100, 0, 0);
        step("p_held", 1, 0, 0, 1, 90, 100, 0, 0);

        // Player_HP = 90 (bar 20..199), NPC_HP = 100 (bar 420..619).
        bar("bar_x20", 20, 25, 1, 0);
        bar("bar_x199", 199, 25, 1, 0);
        bar("bar_x200", 200, 25, 0, 0);
        bar("bar_x19", 19, 25, 0, 0);
        bar("bar_y30", 20, 30, 0, 0);
        bar("bar_y19", 20, 19, 0, 0);
        bar("bar_x420", 420, 25, 0, 1);
        bar("bar_x419", 419, 25, 0, 0);
        bar("bar_x619_y29", 619, 29, 0, 1);
        bar("bar_x620", 620, 25, 0, 0);

        // Bring the player to 70 with invulnerability half spent, then reset mid-cycle.
        frames(30);
        step("p_to80", 1, 0, 0, 1, 80, 100, 0, 0);
        frames(30);
        step("p_to70", 1, 0, 0, 1, 70, 100, 0, 0);
        frames(15);
        #2 Reset = 1'b1;
        push_state("async_reset", 100, 100, 0, 0);
        #1 pop_state();
        cycles(2);
        Reset = 1'b0;
        cycles(1);
        step("post_reset_hit", 1, 0, 0, 1, 90, 100, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/health_tracker.md
Name: health_tracker

Overview:
- Tracks hit points for the player and the NPC during a round.
- Consumes single-cycle hit pulses from the projectile/collision logic and feeds the Player_Dead / NPC_Dead inputs of stage_control.
- Generates per-pixel health-bar flags for color_mapper.
- Runs on the 50 MHz Clk and uses VGA_VS (frame_clk) only as a sampled per-frame timing event.

Parameters:
- MAX_HP, 7'd100, starting and restored HP per fighter (1..127).
- HIT_DAMAGE, 7'd10, HP removed per accepted hit (1..MAX_HP).
- INVULN_FRAMES, 6'd30, frames of hit immunity after an accepted hit (0 = none).
- BAR_Y_TOP, 10'd20, first scanline of both bars.
- BAR_HEIGHT, 10'd10, bar height in lines.
- PLAYER_BAR_X, 10'd20, left edge of the player bar (grows rightward).
- NPC_BAR_X_END, 10'd619, right edge of the NPC bar (grows leftward).

Ports:
- Clk  input  1  system clock (CLOCK_50).
- Reset  input  1  asynchronous, active-high reset.
- frame_clk  input  1  VGA_VS; sampled, not used as a clock.
- Soft_Reset  input  1  synchronous round restart; restores both fighters to full HP.
- game_l  input  1  high while stage_control is in the game state; hits are ignored otherwise.
- Player_Hit  input  1  one-Clk pulse: the player was struck.
- NPC_Hit  input  1  one-Clk pulse: the NPC was struck.
- DrawX  input  10  current pixel column.
- DrawY  input  10  current pixel row.
- Player_HP  output  7  player hit points.
- NPC_HP  output  7  NPC hit points.
- Player_Dead  output  1  high while Player_HP == 0.
- NPC_Dead  output  1  high while NPC_HP == 0.
- is_player_bar  output  1  current pixel lies on the player health bar.
- is_npc_bar  output  1  current pixel lies on the NPC health bar.

Behaviour:
- Reset: asynchronous; Reset is active-high.
  - Reset asserted: Player_HP = NPC_HP = MAX_HP; Dead flags = 0; both invulnerability counters = 0; frame sync flops = 0.
  - Reset wins over every other input, including mid-hit.
- Frame tick:
  - frame_clk passes through a 2-flop synchronizer, then one history flop.
  - frame_tick = sync & ~hist: exactly one Clk cycle per VS rising edge.
- Per fighter (independent, identical logic; player and NPC hits in the same cycle are both processed):
  - Accepted hit = Hit & game_l & ~Dead & (invuln == 0) & ~Soft_Reset.
  - On an accepted hit, on the next Clk edge:
    - HP <= (HP > HIT_DAMAGE) ? HP − HIT_DAMAGE : 0 (saturating, no wrap).
    - invuln <= INVULN_FRAMES.
  - Latency: hit pulse at edge N → HP/Dead updated after edge N+1 (one cycle).
  - Dead is registered and set on the same edge HP reaches 0: Dead <= (HP_next == 0).
  - invuln decrements by 1 on each frame_tick while nonzero.
    - If an accepted hit and a frame_tick coincide, the load wins (counter = INVULN_FRAMES).
  - Hits while invuln != 0, while Dead, or while game_l = 0 are dropped with no effect.
    - They are not queued: a pulse held for several cycles counts as at most one hit, because invuln blocks the later cycles.
    - If INVULN_FRAMES = 0, every asserted cycle is a separate hit; upstream must pulse.
  - Once Dead, HP stays 0 and Dead stays 1 until Reset or Soft_Reset.
- Soft_Reset (synchronous, checked before hits):
  - Next edge: HP = MAX_HP, Dead = 0, invuln = 0.
  - A hit in the same cycle is discarded.
- Health bars (combinational from registered HP and DrawX/DrawY; bar width = 2·HP pixels, computed in 10 bits):
  - Vertical extent for both bars: BAR_Y_TOP ≤ DrawY < BAR_Y_TOP + BAR_HEIGHT.
  - is_player_bar = 1 when in the vertical extent and PLAYER_BAR_X ≤ DrawX < PLAYER_BAR_X + 2·Player_HP.
  - is_npc_bar = 1 when in the vertical extent and NPC_BAR_X_END + 1 − 2·NPC_HP ≤ DrawX ≤ NPC_BAR_X_END.
  - HP = 0 → bar flag never asserts.

Test Plan:
- Reset then idle 5 frames → Player_HP = NPC_HP = 100, Dead flags 0, no HP change.
- game_l = 1, one Player_Hit pulse → Player_HP = 90 one cycle later; second pulse 10 frames later ignored (HP stays 90); pulse after 31 frame ticks → HP = 80.
- game_l = 1, MAX_HP = 100, 10 hits spaced 31 frames apart on NPC → NPC_HP = 0 and NPC_Dead = 1 on the same edge; an 11th hit leaves HP = 0, no wrap. Soft_Reset → NPC_HP = 100, NPC_Dead = 0 next cycle.
- Player_Hit and NPC_Hit in the same cycle → both HP = 90. Hit coincident with Soft_Reset → HP = 100. Hit with game_l = 0 → no change.
- Player_HP = 90: DrawY = 25 with DrawX = 20 and 199 → is_player_bar = 1; DrawX = 200 → 0; DrawY = 30 → 0. NPC_HP = 100: DrawX = 420 → is_npc_bar = 1; DrawX = 419 → 0.
- Assert Reset asynchronously mid-frame after hits (HP = 70, invuln = 15) → outputs return to reset values immediately, without waiting for a Clk edge.
